jstk2_responder: RTL
====================

# jstk2_responder

SPI responder emulating the PMOD JSTK2 side of the joystick link, so the controller's SPI joystick reader can run against synthetic stick data in simulation and on a second board. The block samples CS_n/SCK/MOSI in the CLK domain and answers each 5-byte frame on MISO with a snapshot of programmable X/Y/button values. It also decodes the LED colour command sent on MOSI.

## Interface
Parameters:
- SYNC_STAGES, 2: synchronizer depth on CS_n, SCK and MOSI; legal range 2–3.
- LED_CMD, 8'h84: command byte that selects the set-LED-RGB command.

Ports:
- CLK  input  1  system clock; everything is in this domain.
- RST_N  input  1  asynchronous, active-low reset.
- CS_n  input  1  SPI chip select from the master; active low.
- SCK  input  1  SPI clock from the master; mode 0.
- MOSI  input  1  master-to-responder data.
- MISO  output  1  responder-to-master data, MSB first.
- x_val  input  10  X position to report.
- y_val  input  10  Y position to report.
- btn_val  input  2  button bits: [1] trigger, [0] stick press.
- led_r, led_g, led_b  output  8 each  last accepted RGB values.
- led_upd  output  1  one-CLK pulse when the RGB values update.
- frame_done  output  1  one-CLK pulse when a complete 5-byte frame ends.
- busy  output  1  high while a frame is in progress.

## Operation
- Inputs pass through SYNC_STAGES flops, then a one-flop edge detector that produces sck_rise, sck_fall, cs_fall and cs_rise.
- State machine:
  - IDLE: on cs_fall go to SHIFT.
  - SHIFT: on cs_rise go to IDLE.
  - Reset state is IDLE.
- On cs_fall, snapshot the 40-bit packet:
  - byte0 = x_val[7:0]
  - byte1 = {6'b0, x_val[9:8]}
  - byte2 = y_val[7:0]
  - byte3 = {6'b0, y_val[9:8]}
  - byte4 = {6'b0, btn_val}
- Changes on x_val/y_val/btn_val during a frame do not affect that frame.
- Also on cs_fall: load the tx shift register with the packet, drive MISO = bit 39, and clear bit_cnt (0–7) and byte_cnt (0–5).
- SHIFT, on sck_rise: shift the synchronized MOSI into the rx byte. When bit_cnt = 7, store the rx byte into cmd[byte_cnt], increment byte_cnt (saturates at 5) and wrap bit_cnt to 0.
- SHIFT, on sck_fall: shift the tx register left and present the next bit on MISO. After 40 bits, MISO = 0 until CS_n rises.
- In IDLE, MISO = 0. There is no tristate.
- cs_rise while byte_cnt = 5 and bit_cnt = 0: pulse frame_done.
- cs_rise at any other count, including mid-byte: discard the partial byte, no frame_done, no LED update.
- Bytes clocked beyond 5: MOSI is ignored and MISO stays 0.
- cs_fall and cs_rise detected in the same CLK: impossible after synchronization; no requirement.
- A new cs_fall always restarts the frame from byte0.
- Reset mid-frame forces IDLE. Re-entry needs a fresh cs_fall.

## Timing
- Reset values: MISO = 0, led_r/g/b = 0, led_upd = 0, frame_done = 0, busy = 0, state IDLE.
- Input-to-action latency: SYNC_STAGES + 1 CLK from a pin edge to the corresponding action.
- Legal SCK half-period: at least SYNC_STAGES + 3 CLK cycles.
- Legal CS_n-fall to first SCK rise: at least SYNC_STAGES + 3 CLK cycles.
- MISO changes exactly SYNC_STAGES + 1 CLK after the SCK-fall or CS_n-fall pin edge, and is registered.
- busy rises the CLK after cs_fall and falls the CLK after cs_rise.
- frame_done and led_upd are asserted the CLK after cs_rise, for one cycle, together.

## Configuration
- JSTK2_LED_CMD_EN defined: LED command decode is compiled in.
  - On a complete frame with cmd[0] == LED_CMD, led_r/g/b load cmd[1]/cmd[2]/cmd[3] and led_upd pulses.
  - Any other cmd[0] leaves the LEDs unchanged.
- JSTK2_LED_CMD_EN undefined: the rx path and cmd storage are removed.
  - led_r/g/b = 0 and led_upd = 0 permanently.
  - MOSI is ignored; frame_done still works.

## Test plan
- x_val = 10'h2A5, y_val = 10'h0E4, btn_val = 2'b10; 40-bit frame at SCK half-period 8 CLK -> MISO bytes A5, 02, E4, 00, 02; frame_done pulses once.
- Change x_val to 10'h3FF after byte0 of a frame -> that frame still returns A5, 02; the next frame returns FF, 03.
- With the macro defined, MOSI = 84, 11, 22, 33, 00 -> led_r/g/b = 11/22/33 the CLK after cs_rise, with a one-cycle led_upd.
- CS_n rises after 20 bits with MOSI = 84, 55... -> no frame_done, LEDs keep their prior values, and the next full frame starts at byte0.
- RST_N pulsed low mid-frame -> MISO = 0 and busy = 0 immediately; SCK edges are ignored until a new CS_n fall.
- 48 SCK cycles in one frame -> bits 41–48 on MISO read 0; frame_done pulses at CS_n rise.

Source files
------------

// File: rtl/jstk2_responder.sv
`timescale 1ns/1ps
// jstk2_responder: PMOD JSTK2 SPI responder answering 5-byte frames with X/Y/button snapshots.
// Define JSTK2_LED_CMD_EN to compile in the MOSI set-LED-RGB command decode.
module jstk2_responder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  LED_CMD     = 8'h84
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       CS_n,
    input  logic       SCK,
    input  logic       MOSI,
    output logic       MISO,
    input  logic [9:0] x_val,
    input  logic [9:0] y_val,
    input  logic [1:0] btn_val,
    output logic [7:0] led_r,
    output logic [7:0] led_g,
    output logic [7:0] led_b,
    output logic       led_upd,
    output logic       frame_done,
    output logic       busy
);
    localparam int unsigned PKT_W  = 40;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned NBYTES = 5;

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, sck_sync_q;
    logic                   cs_prev_q, sck_prev_q;
    logic                   cs_s, sck_s;
    logic                   cs_fall, cs_rise, sck_rise, sck_fall;
    logic                   load_c, rx_c, tx_c, end_c, done_c;
    logic [PKT_W-1:0]       pkt_c;
    logic [PKT_W-2:0]       tx_q;
    logic                   miso_q, busy_q, frame_done_q;
    logic [CNT_W-1:0]       bit_cnt_q, byte_cnt_q;

    // CS chain resets low so a CS_n held low across reset never fakes a fresh frame start
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cs_sync_q  <= '0;
            sck_sync_q <= '0;
            cs_prev_q  <= 1'b0;
            sck_prev_q <= 1'b0;
        end else begin
            cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], CS_n};
            sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], SCK};
            cs_prev_q  <= cs_s;
            sck_prev_q <= sck_s;
        end
    end

    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign cs_fall  = cs_prev_q & ~cs_s;
    assign cs_rise  = ~cs_prev_q & cs_s;
    assign sck_rise = ~sck_prev_q & sck_s;
    assign sck_fall = sck_prev_q & ~sck_s;

    assign pkt_c = {x_val[7:0], 6'b0, x_val[9:8], y_val[7:0], 6'b0, y_val[9:8], 6'b0, btn_val};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cs_fall) state_d = SHIFT;
            SHIFT:   if (cs_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load_c = cs_fall;
        rx_c   = 1'b0;
        tx_c   = 1'b0;
        end_c  = 1'b0;
        if (state_q == SHIFT) begin
            rx_c  = sck_rise;
            tx_c  = sck_fall;
            end_c = cs_rise;
        end
        done_c = end_c && (byte_cnt_q == CNT_W'(NBYTES)) && (bit_cnt_q == '0);
    end

    // Zeros shift in behind the packet, so MISO reads 0 past bit 40 without extra logic
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tx_q         <= '0;
            miso_q       <= 1'b0;
            bit_cnt_q    <= '0;
            byte_cnt_q   <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            busy_q       <= (state_d == SHIFT);
            frame_done_q <= done_c;
            if (load_c) begin
                tx_q       <= pkt_c[PKT_W-2:0];
                miso_q     <= pkt_c[PKT_W-1];
                bit_cnt_q  <= '0;
                byte_cnt_q <= '0;
            end else begin
                if (tx_c) begin
                    tx_q   <= {tx_q[PKT_W-3:0], 1'b0};
                    miso_q <= tx_q[PKT_W-2];
                end
                if (end_c) miso_q <= 1'b0;
                if (rx_c) begin
                    if (bit_cnt_q == CNT_W'(BYTE_W - 1)) begin
                        bit_cnt_q <= '0;
                        if (byte_cnt_q != CNT_W'(NBYTES)) byte_cnt_q <= byte_cnt_q + CNT_W'(1);
                    end else begin
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                    end
                end
            end
        end
    end

`ifdef JSTK2_LED_CMD_EN
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [BYTE_W-2:0]      rx_q;
    logic [BYTE_W-1:0]      cmd_q [4];
    logic [BYTE_W-1:0]      led_r_q, led_g_q, led_b_q;
    logic                   led_upd_q;

    // Only command bytes 0..3 matter; byte 4 and overrun bytes are dropped
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mosi_sync_q <= '0;
            rx_q        <= '0;
            for (int i = 0; i < 4; i++) cmd_q[i] <= '0;
            led_r_q     <= '0;
            led_g_q     <= '0;
            led_b_q     <= '0;
            led_upd_q   <= 1'b0;
        end else begin
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
            led_upd_q   <= 1'b0;
            if (load_c) begin
                rx_q <= '0;
            end else if (rx_c) begin
                rx_q <= {rx_q[BYTE_W-3:0], mosi_sync_q[SYNC_STAGES-1]};
                if (bit_cnt_q == CNT_W'(BYTE_W - 1) && byte_cnt_q < CNT_W'(4))
                    cmd_q[byte_cnt_q[1:0]] <= {rx_q, mosi_sync_q[SYNC_STAGES-1]};
            end
            if (done_c && cmd_q[0] == LED_CMD) begin
                led_r_q   <= cmd_q[1];
                led_g_q   <= cmd_q[2];
                led_b_q   <= cmd_q[3];
                led_upd_q <= 1'b1;
            end
        end
    end

    assign led_r   = led_r_q;
    assign led_g   = led_g_q;
    assign led_b   = led_b_q;
    assign led_upd = led_upd_q;
`else
    logic unused_mosi;
    assign unused_mosi = MOSI;
    assign led_r       = '0;
    assign led_g       = '0;
    assign led_b       = '0;
    assign led_upd     = 1'b0;
`endif

    assign MISO       = miso_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule
